// File: rtl/vid_scanout_fetch.sv
// Scanout fetch engine: walks a framebuffer line by line (each source line
// fetched LINE_REPEAT times), buffers returned words in a small FIFO and
// serialises them into 8-bit palette indices, low byte first.
module vid_scanout_fetch #(
    parameter int H_WORDS     = 80,
    parameter int V_LINES     = 200,
    parameter int LINE_REPEAT = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic [13:0] fb_base,
    output logic [13:0] v_addr_0,
    output logic        v_re_0,
    input  logic [31:0] v_data_1,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        stat_underrun,
    output logic        stat_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int XW = (H_WORDS > 1) ? $clog2(H_WORDS) : 1;
    localparam int RW = (LINE_REPEAT > 1) ? $clog2(LINE_REPEAT) : 1;
    localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Little-endian byte lane selection of a framebuffer word.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    state_t          state_r;
    logic [13:0]     line_r;
    logic [XW-1:0]   x_r;
    logic [RW-1:0]   rep_r;
    logic [YW-1:0]   y_r;
    logic            re_r;
    logic [13:0]     addr_r;
    logic            last_r;
    logic            done_r;
    logic            inflight_r;

    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     cnt_r;
    logic [1:0]      idx_r;

    logic            re_eff_s;
    logic            accept_s;
    logic            pop_s;
    logic            push_s;
    logic [AW:0]     cnt_next_s;
    logic            room_s;
    logic            issue_s;
    logic [XW-1:0]   src_x_s;
    logic [RW-1:0]   src_rep_s;
    logic [YW-1:0]   src_y_s;
    logic [13:0]     src_line_s;
    logic [13:0]     issue_addr_s;
    logic            x_end_s;
    logic            rep_end_s;
    logic            y_end_s;
    logic            final_s;
    logic [XW-1:0]   nxt_x_s;
    logic [RW-1:0]   nxt_rep_s;
    logic [YW-1:0]   nxt_y_s;
    logic [13:0]     nxt_line_s;

    // Read issue decision, FIFO bookkeeping and next fetch position.
    always_comb begin
        // A read scheduled for the frame_start cycle belongs to the old frame
        // and is suppressed at the pin.
        re_eff_s   = re_r & ~frame_start;
        pix_valid  = (cnt_r != '0);
        accept_s   = pix_valid & pix_ready;
        pop_s      = accept_s & (idx_r == 2'd3);
        push_s     = inflight_r & ~frame_start;
        cnt_next_s = cnt_r + (AW+1)'(push_s) - (AW+1)'(pop_s);
        // Occupancy after this edge plus the read already on the bus must leave a slot.
        room_s     = (({1'b0, cnt_next_s}) + (AW+2)'(re_r)) < (AW+2)'(FIFO_DEPTH);

        if (frame_start) begin
            issue_s    = 1'b1;
            src_x_s    = '0;
            src_rep_s  = '0;
            src_y_s    = '0;
            src_line_s = fb_base;
        end else begin
            issue_s    = (state_r == ST_FETCH) & ~last_r & room_s;
            src_x_s    = x_r;
            src_rep_s  = rep_r;
            src_y_s    = y_r;
            src_line_s = line_r;
        end

        issue_addr_s = src_line_s + 14'(src_x_s);
        x_end_s      = (src_x_s == XW'(H_WORDS - 1));
        rep_end_s    = (src_rep_s == RW'(LINE_REPEAT - 1));
        y_end_s      = (src_y_s == YW'(V_LINES - 1));
        final_s      = x_end_s & rep_end_s & y_end_s;

        nxt_x_s    = src_x_s + XW'(1);
        nxt_rep_s  = src_rep_s;
        nxt_y_s    = src_y_s;
        nxt_line_s = src_line_s;
        if (x_end_s) begin
            nxt_x_s = '0;
            if (rep_end_s) begin
                nxt_rep_s  = '0;
                nxt_line_s = src_line_s + 14'(H_WORDS);
                if (y_end_s) begin
                    nxt_y_s = '0;
                end else begin
                    nxt_y_s = src_y_s + YW'(1);
                end
            end else begin
                nxt_rep_s = src_rep_s + RW'(1);
            end
        end else begin
            nxt_x_s = src_x_s + XW'(1);
        end

        v_re_0        = re_eff_s;
        v_addr_0      = addr_r;
        stat_done     = done_r;
        stat_underrun = (state_r == ST_FETCH) & pix_ready & ~pix_valid;
        if (pix_valid) begin
            pix_data = byte_sel(mem_r[rd_ptr_r], idx_r);
        end else begin
            pix_data = 8'd0;
        end
    end

    // Frame state machine and fetch address generator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            line_r     <= 14'd0;
            x_r        <= '0;
            rep_r      <= '0;
            y_r        <= '0;
            re_r       <= 1'b0;
            addr_r     <= 14'd0;
            last_r     <= 1'b0;
            done_r     <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_start) state_r <= ST_FETCH;
                    else             state_r <= ST_IDLE;
                end
                ST_FETCH: begin
                    if (frame_start)  state_r <= ST_FETCH;
                    else if (last_r)  state_r <= ST_DONE;
                    else              state_r <= ST_FETCH;
                end
                ST_DONE: begin
                    if (frame_start) state_r <= ST_FETCH;
                    else             state_r <= ST_DONE;
                end
                default: state_r <= ST_IDLE;
            endcase

            // Done flags the cycle after the final read was on the bus.
            if (frame_start) begin
                done_r <= 1'b0;
            end else if ((state_r == ST_FETCH) && last_r) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end

            re_r       <= issue_s;
            inflight_r <= re_eff_s;
            if (issue_s) begin
                addr_r <= issue_addr_s;
                x_r    <= nxt_x_s;
                rep_r  <= nxt_rep_s;
                y_r    <= nxt_y_s;
                line_r <= nxt_line_s;
                last_r <= final_s;
            end else begin
                last_r <= 1'b0;
            end
        end
    end

    // FIFO pointers, occupancy and byte index of the head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            idx_r    <= 2'd0;
        end else if (frame_start) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            idx_r    <= 2'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            cnt_r <= cnt_next_s;
            if (accept_s) idx_r <= idx_r + 2'd1;
        end
    end

    // FIFO storage; contents are only observed while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= v_data_1;
        end
    end

endmodule
